bidir_pin_ctrl: RTL and testbench
=================================

# bidir_pin_ctrl

Sequencer for a `bidir_pin` instance. It shares the pin bank between a write requester and a read requester using round-robin arbitration. It owns the `dir`/`data_out` controls, enforces bus-release turnaround after every drive burst, and synchronises `data_in` before returning read data. It sits between the `bidir_pin` pad wrapper and the core-side logic.

## Interface
- `WIDTH`, 1: pin bank width.
- `TURN_CYCLES`, 2: released (`dir`=0) cycles after a drive burst before the next grant; legal range 1..15.
- `SYNC_STAGES`, 2: flop stages on `data_in`; legal range 2..4.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_valid` in 1: write beat pending.
- `wr_data` in WIDTH: write beat value.
- `wr_ready` out 1: beat accepted this cycle (valid && ready = transfer).
- `rd_req` in 1: level read request.
- `rd_valid` out 1: one-cycle read response strobe.
- `rd_data` out WIDTH: synchronised pin value; held until the next response.
- `dir` out 1: to `bidir_pin.dir`; 1 = drive pin, 0 = release.
- `data_out` out WIDTH: to `bidir_pin.data_out`.
- `data_in` in WIDTH: from `bidir_pin.data_in`; asynchronous to `clk`.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, DRIVE, TURN, CAPTURE, RESP.
- **IDLE**
  - `dir`=0, `data_out`=0.
  - If only `wr_valid`: grant write.
  - If only `rd_req`: grant read.
  - If both: grant the class not granted last (`last_grant` flag; reset value = read, so write wins first).
  - Write grant: `wr_ready`=1 this cycle, capture `wr_data`, go to DRIVE, `last_grant`=write.
  - Read grant: go to CAPTURE, `last_grant`=read.
- **DRIVE**
  - `dir`=1, `data_out` = captured beat (registered outputs).
  - If `wr_valid` && !`rd_req`: `wr_ready`=1, capture the new beat, stay in DRIVE (burst).
  - Otherwise go to TURN; `wr_ready`=0.
- **TURN**
  - `dir`=0, `data_out`=0.
  - Counts TURN_CYCLES cycles, then goes to IDLE. No grant is taken during TURN.
- **CAPTURE**
  - `dir`=0.
  - Waits SYNC_STAGES cycles so the sync chain holds only post-release samples, then goes to RESP.
- **RESP**
  - `rd_valid`=1 for one cycle; `rd_data` loads the sync-chain output.
  - Next state is IDLE.
  - A requester that keeps `rd_req` high past RESP gets another read, subject to arbitration.
- `dir` is never 1 outside DRIVE. `wr_ready` is never 1 outside IDLE or DRIVE.
- The sync chain samples `data_in` every cycle regardless of state.

## Timing
- All outputs are registered except `wr_ready`, which is decoded from state and inputs.
- Reset values: `dir`=0, `data_out`=0, `rd_valid`=0, `rd_data`=0, `busy`=0, `wr_ready`=0. Also: state IDLE, counters 0, sync chain 0, `last_grant`=read.
- **Write latency.** Accept at cycle N (IDLE):
  - `dir`=1 and `data_out`=beat at N+1.
  - `dir`=0 at N+2 (TURN).
  - Back in IDLE at N+2+TURN_CYCLES.
  - A k-beat burst holds `dir`=1 for k consecutive cycles.
- **Read latency.** Grant at cycle N:
  - CAPTURE for N+1..N+SYNC_STAGES.
  - `rd_valid` at N+SYNC_STAGES+1.
  - IDLE at N+SYNC_STAGES+2.
- **Simultaneous events.**
  - `rd_req` rising during DRIVE terminates the burst after the current beat.
  - `wr_valid` dropping mid-burst goes to TURN.
  - Requests arriving during TURN, CAPTURE or RESP wait for IDLE.
- **Reset mid-operation.** Asserting `rst_n` low forces `dir`=0 asynchronously, so the pin is released immediately. Any in-flight beat or read is discarded and no `rd_valid` is issued.

## Structure
- Package `bidir_pkg`:
  - state enum `bidir_state_t` (IDLE, DRIVE, TURN, CAPTURE, RESP);
  - constants `DIR_DRIVE`=1 and `DIR_RELEASE`=0;
  - grant enum (GNT_WR, GNT_RD).
- Sub-module `bidir_sync`: WIDTH-wide, SYNC_STAGES-deep flop chain with asynchronous active-low clear.
- Top level contains the FSM, turnaround/capture counter, `last_grant` flag and output registers.

## Test plan
1. **Reset.** `rst_n` low mid-DRIVE with `dir`=1 → `dir`=0 immediately, without waiting for a clock edge. After release, `busy`=0 and `rd_valid`=0.
2. **Single write.** WIDTH=4, TURN_CYCLES=2, `wr_data`=4'hA at N → `wr_ready`@N; `dir`=1 and `data_out`=4'hA @N+1; `dir`=0 @N+2..N+3; `busy`=0 @N+4.
3. **Burst.** Beats 4'h1, 4'h2, 4'h3 on consecutive cycles → `dir`=1 for exactly 3 cycles with `data_out` 1, 2, 3, then 2 TURN cycles.
4. **Read.** Bench drives `data_in`=4'h5, SYNC_STAGES=2, grant at N → `rd_valid`=1 and `rd_data`=4'h5 at N+3, and only there; `dir`=0 throughout.
5. **Contention.** `wr_valid` and `rd_req` both held high from reset → grants alternate write, read, write. No cycle has `dir`=1 within TURN_CYCLES cycles of any CAPTURE entry.
6. **Preemption.** `rd_req` rises during the second beat of a 4-beat burst → burst ends after beat 2, TURN runs, then the read is granted before beat 3.

Source files
------------

// File: rtl/bidir_pkg.sv
// bidir_pkg
//   Shared types and constants for the bidir_pin sequencer.
//   - bidir_state_t : sequencer FSM states
//   - grant_t       : which requester class was granted most recently
//   - DIR_DRIVE / DIR_RELEASE : encodings of the bidir_pin.dir control
package bidir_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    TURN    = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } bidir_state_t;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_t;

  localparam logic DIR_DRIVE   = 1'b1;
  localparam logic DIR_RELEASE = 1'b0;

  // Counters are 4 bits wide; TURN_CYCLES tops out at 15.
  localparam int CNT_W = 4;

  // Load value for a counter that must run for 'cycles' states
  // (the terminal-count compare fires on zero).
  function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/bidir_sync.sv
// bidir_sync
//   WIDTH-wide, STAGES-deep flop chain used to bring the asynchronous
//   pad input into the clk domain. Cleared asynchronously by rst_n.
// Ports:
//   clk   in  1      : clock
//   rst_n in  1      : asynchronous active-low clear
//   d     in  WIDTH  : asynchronous input
//   q     out WIDTH  : synchronised output (last stage)
module bidir_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg <= '0;
    end else begin
      stg <= {stg[STAGES-2:0], d};
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/bidir_pin_ctrl.sv
// bidir_pin_ctrl
//   Sequencer for a bidir_pin pad instance. Arbitrates the pin bank
//   between a write requester and a read requester (round-robin on
//   contention), owns dir/data_out, inserts a released turnaround after
//   every drive burst and returns synchronised read data.
// Ports:
//   clk      in  1     : clock, rising edge
//   rst_n    in  1     : asynchronous active-low reset
//   wr_valid in  1     : write beat pending
//   wr_data  in  WIDTH : write beat value
//   wr_ready out 1     : beat accepted this cycle (combinational)
//   rd_req   in  1     : level read request
//   rd_valid out 1     : one-cycle read response strobe
//   rd_data  out WIDTH : synchronised pin value, held until next response
//   dir      out 1     : 1 = drive pin, 0 = release
//   data_out out WIDTH : value driven onto the pin
//   data_in  in  WIDTH : pin value, asynchronous to clk
//   busy     out 1     : high whenever the FSM is not in IDLE
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | pin released; arbitrate between wr_valid and rd_req
// DRIVE   | dir=1, data_out = current beat; extend burst while writes flow
// TURN    | pin released for TURN_CYCLES cycles before any new grant
// CAPTURE | pin released; wait SYNC_STAGES cycles to flush the sync chain
// RESP    | rd_valid strobe, rd_data holds the sampled pin value
module bidir_pin_ctrl
  import bidir_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int TURN_CYCLES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             dir,
  output logic [WIDTH-1:0] data_out,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy
);

  localparam logic [CNT_W-1:0] TURN_LOAD = cnt_load(TURN_CYCLES);
  localparam logic [CNT_W-1:0] SYNC_LOAD = cnt_load(SYNC_STAGES);

  bidir_state_t     state;
  grant_t           last_grant;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sync_q;

  logic gnt_wr;
  logic gnt_rd;
  logic burst_go;
  logic cnt_done;

  bidir_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (data_in),
    .q     (sync_q)
  );

  // Round-robin: on contention the class not granted last wins.
  always_comb begin
    gnt_wr   = 1'b0;
    gnt_rd   = 1'b0;
    burst_go = 1'b0;
    if (state == IDLE) begin
      gnt_wr = wr_valid && (!rd_req || (last_grant == GNT_RD));
      gnt_rd = rd_req && !gnt_wr;
    end
    // A pending read ends the burst after the beat currently on the pin.
    if (state == DRIVE) begin
      burst_go = wr_valid && !rd_req;
    end
  end

  assign wr_ready = gnt_wr || burst_go;
  assign cnt_done = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GNT_RD;
      cnt        <= '0;
      dir        <= DIR_RELEASE;
      data_out   <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      busy       <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_wr) begin
            state      <= DRIVE;
            last_grant <= GNT_WR;
            dir        <= DIR_DRIVE;
            data_out   <= wr_data;
            busy       <= 1'b1;
          end else if (gnt_rd) begin
            state      <= CAPTURE;
            last_grant <= GNT_RD;
            cnt        <= SYNC_LOAD;
            busy       <= 1'b1;
          end
        end

        DRIVE: begin
          if (burst_go) begin
            data_out <= wr_data;
          end else begin
            state    <= TURN;
            dir      <= DIR_RELEASE;
            data_out <= '0;
            cnt      <= TURN_LOAD;
          end
        end

        TURN: begin
          if (cnt_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        CAPTURE: begin
          // Entering RESP: the chain now only holds post-release samples.
          if (cnt_done) begin
            state    <= RESP;
            rd_valid <= 1'b1;
            rd_data  <= sync_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          dir      <= DIR_RELEASE;
          data_out <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bidir_pin_ctrl.sv
// tb_bidir_pin_ctrl
//   Directed bench for bidir_pin_ctrl with WIDTH=4, TURN_CYCLES=2,
//   SYNC_STAGES=2. Inputs change 1 ns after each rising edge; outputs
//   are checked 2 ns after the edge.
module tb_bidir_pin_ctrl;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             wr_valid;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready;
  logic             rd_req;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             dir;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] data_in;
  logic             busy;

  int tests_run = 0;
  int tests_failed = 0;

  bidir_pin_ctrl #(
    .WIDTH       (WIDTH),
    .TURN_CYCLES (2),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_req   (rd_req),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .dir      (dir),
    .data_out (data_out),
    .data_in  (data_in),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_req   = 1'b0;
    data_in  = '0;
    repeat (3) cyc();
    #1;
    chk("rst_dir",      dir,      0);
    chk("rst_data_out", data_out, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data",  rd_data,  0);
    chk("rst_busy",     busy,     0);
    chk("rst_wr_ready", wr_ready, 0);

    // ---- 1. reset mid-DRIVE releases the pin without a clock edge
    cyc();
    rst_n = 1'b1;
    wr_valid = 1'b1; wr_data = 4'hF;
    #1;
    chk("t1_accept", wr_ready, 1);
    cyc();
    wr_valid = 1'b0;
    #1;
    chk("t1_drive_dir", dir, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t1_async_dir",  dir,      0);
    chk("t1_async_dout", data_out, 0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("t1_post_busy",  busy,     0);
    chk("t1_post_rdv",   rd_valid, 0);
    chk("t1_post_dir",   dir,      0);

    // ---- 2. single write, beat A
    cyc();
    wr_valid = 1'b1; wr_data = 4'hA;
    #1;
    chk("t2_n_wr_ready", wr_ready, 1);
    chk("t2_n_dir",      dir,      0);
    chk("t2_n_busy",     busy,     0);
    cyc();                                   // N+1
    wr_valid = 1'b0;
    #1;
    chk("t2_n1_dir",      dir,      1);
    chk("t2_n1_data_out", data_out, 4'hA);
    chk("t2_n1_busy",     busy,     1);
    chk("t2_n1_wr_ready", wr_ready, 0);
    cyc();                                   // N+2
    #1;
    chk("t2_n2_dir",  dir,      0);
    chk("t2_n2_dout", data_out, 0);
    chk("t2_n2_busy", busy,     1);
    cyc();                                   // N+3: no grant during TURN
    wr_valid = 1'b1; wr_data = 4'h1;
    #1;
    chk("t2_n3_dir",      dir,      0);
    chk("t2_n3_busy",     busy,     1);
    chk("t2_n3_no_grant", wr_ready, 0);

    // ---- 3. burst 1,2,3 (M = N+4)
    cyc();                                   // M
    #1;
    chk("t2_n4_busy",     busy,     0);
    chk("t3_m_wr_ready",  wr_ready, 1);
    chk("t3_m_dir",       dir,      0);
    cyc();                                   // M+1
    wr_data = 4'h2;
    #1;
    chk("t3_m1_dir",      dir,      1);
    chk("t3_m1_dout",     data_out, 4'h1);
    chk("t3_m1_wr_ready", wr_ready, 1);
    cyc();                                   // M+2
    wr_data = 4'h3;
    #1;
    chk("t3_m2_dir",      dir,      1);
    chk("t3_m2_dout",     data_out, 4'h2);
    chk("t3_m2_wr_ready", wr_ready, 1);
    cyc();                                   // M+3
    wr_valid = 1'b0;
    data_in  = 4'h5;
    #1;
    chk("t3_m3_dir",      dir,      1);
    chk("t3_m3_dout",     data_out, 4'h3);
    chk("t3_m3_wr_ready", wr_ready, 0);
    cyc();                                   // M+4
    #1;
    chk("t3_m4_dir",  dir,  0);
    chk("t3_m4_busy", busy, 1);
    cyc();                                   // M+5
    #1;
    chk("t3_m5_dir",  dir,  0);
    chk("t3_m5_busy", busy, 1);

    // ---- 4. read, data_in = 5 (grant at R)
    cyc();                                   // R
    rd_req = 1'b1;
    #1;
    chk("t3_m6_busy",     busy,     0);
    chk("t4_r_wr_ready",  wr_ready, 0);
    chk("t4_r_rd_valid",  rd_valid, 0);
    cyc();                                   // R+1
    rd_req = 1'b0;
    #1;
    chk("t4_r1_busy",     busy,     1);
    chk("t4_r1_dir",      dir,      0);
    chk("t4_r1_rd_valid", rd_valid, 0);
    cyc();                                   // R+2
    #1;
    chk("t4_r2_dir",      dir,      0);
    chk("t4_r2_rd_valid", rd_valid, 0);
    cyc();                                   // R+3
    #1;
    chk("t4_r3_rd_valid", rd_valid, 1);
    chk("t4_r3_rd_data",  rd_data,  4'h5);
    chk("t4_r3_dir",      dir,      0);
    cyc();                                   // R+4
    #1;
    chk("t4_r4_rd_valid", rd_valid, 0);
    chk("t4_r4_rd_data",  rd_data,  4'h5);
    chk("t4_r4_busy",     busy,     0);

    // ---- 5. contention from reset: write, read, write
    rst_n = 1'b0;
    wr_valid = 1'b1; wr_data = 4'h7;
    rd_req = 1'b1;
    data_in = 4'h9;
    #1;
    chk("t5_rst_rd_data", rd_data, 0);
    cyc();
    cyc();
    rst_n = 1'b1;                            // C0
    #1;
    chk("t5_c0_wr_ready", wr_ready, 1);
    cyc();                                   // C1
    #1;
    chk("t5_c1_dir",      dir,      1);
    chk("t5_c1_dout",     data_out, 4'h7);
    chk("t5_c1_wr_ready", wr_ready, 0);
    cyc();                                   // C2
    #1;
    chk("t5_c2_dir", dir, 0);
    cyc();                                   // C3
    #1;
    chk("t5_c3_dir", dir, 0);
    cyc();                                   // C4: read wins
    #1;
    chk("t5_c4_busy",     busy,     0);
    chk("t5_c4_wr_ready", wr_ready, 0);
    cyc();                                   // C5: CAPTURE entry
    #1;
    chk("t5_c5_dir",  dir,  0);
    chk("t5_c5_busy", busy, 1);
    cyc();                                   // C6
    #1;
    chk("t5_c6_dir", dir, 0);
    chk("t5_c6_wr_ready", wr_ready, 0);
    cyc();                                   // C7: RESP
    #1;
    chk("t5_c7_rd_valid", rd_valid, 1);
    chk("t5_c7_rd_data",  rd_data,  4'h9);
    chk("t5_c7_dir",      dir,      0);
    cyc();                                   // C8: write wins
    #1;
    chk("t5_c8_wr_ready", wr_ready, 1);
    chk("t5_c8_rd_valid", rd_valid, 0);
    cyc();                                   // C9
    wr_valid = 1'b0; rd_req = 1'b0;
    #1;
    chk("t5_c9_dir",  dir,      1);
    chk("t5_c9_dout", data_out, 4'h7);
    cyc();                                   // C10
    cyc();                                   // C11
    cyc();                                   // C12
    #1;
    chk("t5_c12_busy", busy, 0);

    // ---- 6. preemption of a 4-beat burst by rd_req
    wr_valid = 1'b1; wr_data = 4'h1;         // P0
    #1;
    chk("t6_p0_wr_ready", wr_ready, 1);
    cyc();                                   // P1
    wr_data = 4'h2;
    #1;
    chk("t6_p1_dout",     data_out, 4'h1);
    chk("t6_p1_wr_ready", wr_ready, 1);
    cyc();                                   // P2: read request appears
    wr_data = 4'h3;
    rd_req = 1'b1;
    #1;
    chk("t6_p2_dir",      dir,      1);
    chk("t6_p2_dout",     data_out, 4'h2);
    chk("t6_p2_wr_ready", wr_ready, 0);
    cyc();                                   // P3
    #1;
    chk("t6_p3_dir",      dir,      0);
    chk("t6_p3_wr_ready", wr_ready, 0);
    cyc();                                   // P4
    #1;
    chk("t6_p4_dir",      dir,      0);
    chk("t6_p4_busy",     busy,     1);
    cyc();                                   // P5: read before beat 3
    #1;
    chk("t6_p5_busy",     busy,     0);
    chk("t6_p5_wr_ready", wr_ready, 0);
    cyc();                                   // P6
    rd_req = 1'b0;
    #1;
    chk("t6_p6_dir",  dir,  0);
    chk("t6_p6_busy", busy, 1);
    cyc();                                   // P7
    cyc();                                   // P8
    #1;
    chk("t6_p8_rd_valid", rd_valid, 1);
    chk("t6_p8_rd_data",  rd_data,  4'h9);
    cyc();                                   // P9: beat 3 granted
    #1;
    chk("t6_p9_wr_ready", wr_ready, 1);
    cyc();                                   // P10
    wr_valid = 1'b0;
    #1;
    chk("t6_p10_dir",  dir,      1);
    chk("t6_p10_dout", data_out, 4'h3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
